branch_rs_queue: RTL and testbench
==================================

BRANCH_RS_QUEUE -- requirements
Module: branch_rs_queue

Interface
REQ-001 Parameters SHALL be, one per line, name, default, meaning:
  WORD_SIZE  32  operand and CDB data width
  RB_INDEX   4   reorder-buffer tag width
  RB_SIZE    16  CDB channel count, one per RB tag
  DEPTH      4   number of RS entries (power of two, >=2)
REQ-002 Ports SHALL be, one per line, name, direction, width, meaning:
  clk          in   1                 clock
  reset        in   1                 synchronous, active-high reset
  flush        in   1                 mispredict flush; discards all entries
  issue_valid  in   1                 issue request this cycle
  issue_op     in   3                 compare mode
  issue_dest   in   RB_INDEX          RB tag of the branch
  issue_vj     in   WORD_SIZE         operand j value
  issue_qj_pend in  1                 operand j awaits tag issue_qj
  issue_qj     in   RB_INDEX          operand j producer tag
  issue_vk     in   WORD_SIZE         operand k value or immediate
  issue_qk_pend in  1                 operand k awaits tag issue_qk
  issue_qk     in   RB_INDEX          operand k producer tag
  cdb_data     in   WORD_SIZE*RB_SIZE CDB data, slot t at bits [t*WORD_SIZE +: WORD_SIZE]
  cdb_valid    in   RB_SIZE           CDB valid per tag
  full         out  1                 no free entry
  result_valid out  1                 one-cycle result strobe
  result_taken out  1                 branch outcome
  result_dest  out  RB_INDEX          RB tag of the result
REQ-003 Single clock domain, clk rising edge; reset synchronous, active-high.

Function
REQ-004 issue_op encodings SHALL be 0 BGE, 1 BLT, 2 BEQ, 3 BNE, 4 BGEU, 5 BLTU; BGE/BLT compare signed, BGEU/BLTU compare unsigned; codes 6-7 SHALL evaluate as not-taken.
REQ-005 Each entry SHALL hold busy, op, dest, Vj, Vk, pend_j, pend_k, Qj, Qk.
REQ-006 full SHALL be high exactly when all DEPTH entries are busy; it is derived from registered state only.
REQ-007 Issue SHALL be accepted when issue_valid && !full && !flush; the entry allocated SHALL be the lowest-index free one; otherwise the issue is dropped with no side effect.
REQ-008 At issue, a pending operand whose tag has cdb_valid high in the same cycle SHALL be captured from cdb_data and stored as not pending (same-cycle bypass).
REQ-009 Every cycle, each busy entry with a pending operand SHALL capture cdb_data slot Q and clear pending when cdb_valid[Q] is high; both operands may capture in the same cycle.
REQ-010 An entry SHALL be ready when busy and both pending flags are clear in registered state; an entry issued with both operands available becomes ready one cycle after issue.
REQ-011 Among ready entries the oldest by issue order SHALL be selected, tracked with a DEPTH x DEPTH age matrix; at most one result per cycle.
REQ-012 The selected entry's compare result SHALL be registered: result_valid high, result_taken and result_dest valid for exactly the next cycle; the entry's busy SHALL clear on that same edge.
REQ-013 Minimum latency issue-to-result_valid SHALL be 2 cycles: issue at edge N, select at edge N+1, result_valid high between edges N+1 and N+2.
REQ-014 When result_valid is low, result_taken SHALL be 0 and result_dest SHALL be 0.
REQ-015 An entry freed at edge N SHALL be allocatable by an issue sampled at edge N+1, not earlier; issue when full SHALL be dropped even if an entry completes in the same cycle.
REQ-016 flush SHALL clear all busy bits and the age matrix at the next edge, suppress any result selected in that cycle (result_valid 0 next cycle), and drop any simultaneous issue.
REQ-017 Comparison width SHALL be WORD_SIZE; no truncation or extension of Vj/Vk.

Reset
REQ-018 On reset high at an edge: all busy, pending flags and age matrix SHALL clear; result_valid 0, result_taken 0, result_dest 0; full 0 thereafter; reset dominates flush and issue.
REQ-019 Reset mid-operation SHALL discard all in-flight entries with no result emitted.

Structure
REQ-020 Op encodings, parameter defaults and the reset value of dest SHALL reside in shared package branch_rs_pkg.
REQ-021 Compare logic SHALL be a combinational sub-module branch_cmp (op, a, b -> taken); entry storage and select stay in branch_rs_queue.

Verification
REQ-022 Issue BGE Vj=5, Vk=3, no pending, dest=7 -> result_valid 2 cycles later, taken=1, dest=7, one cycle wide.
REQ-023 Issue BLT Vj=-1 (0xFFFFFFFF), Vk=1 then BLTU same operands -> taken=1 then taken=0.
REQ-024 Issue BEQ pending j on tag 3, Vk=9; CDB tag 3 = 9 two cycles later -> taken=1 one cycle after capture cycle +1; CDB tag 3 valid in issue cycle -> bypass, 2-cycle latency.
REQ-025 Fill 4 entries, full=1; fifth issue dropped; oldest entry wakes last but all ready -> results emitted in issue order, one per cycle.
REQ-026 Two busy entries, assert flush in cycle one was selected -> no result_valid next cycle, full 0, new issue accepted next cycle; repeat with reset -> same, outputs 0.

Source files
------------

// File: rtl/branch_rs_pkg.sv
// ---------------------------------------------------------------------------
// branch_rs_pkg
// Shared definitions for the branch reservation-station queue: parameter
// defaults, the branch compare-mode encoding and the idle value driven on
// result_dest.
// ---------------------------------------------------------------------------
package branch_rs_pkg;

    localparam int WORD_SIZE_DEF = 32;  // operand / CDB data width
    localparam int RB_INDEX_DEF  = 4;   // reorder-buffer tag width
    localparam int RB_SIZE_DEF   = 16;  // CDB channels, one per RB tag
    localparam int DEPTH_DEF     = 4;   // reservation-station entries

    // Compare modes carried on issue_op. Codes 6 and 7 are reserved and
    // always resolve as not-taken.
    typedef enum logic [2:0] {
        OP_BGE  = 3'd0,
        OP_BLT  = 3'd1,
        OP_BEQ  = 3'd2,
        OP_BNE  = 3'd3,
        OP_BGEU = 3'd4,
        OP_BLTU = 3'd5,
        OP_RSV6 = 3'd6,
        OP_RSV7 = 3'd7
    } op_e;

    // Value of result_dest whenever result_valid is low (sliced to RB_INDEX).
    localparam logic [31:0] DEST_RESET = 32'd0;

endpackage

// File: rtl/branch_rs_queue_if.sv
// ---------------------------------------------------------------------------
// branch_rs_queue_if
// Bundles the issue port, CDB broadcast, flush and result port of the branch
// reservation station. clk and reset stay plain ports on the design.
//   master : issue/dispatch side (drives issue_*, cdb_*, flush)
//   slave  : reservation station (drives full, result_*)
// ---------------------------------------------------------------------------
interface branch_rs_queue_if
    import branch_rs_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int RB_INDEX  = RB_INDEX_DEF,
    parameter int RB_SIZE   = RB_SIZE_DEF
) ();

    logic                         flush;
    logic                         issue_valid;
    logic [2:0]                   issue_op;
    logic [RB_INDEX-1:0]          issue_dest;
    logic [WORD_SIZE-1:0]         issue_vj;
    logic                         issue_qj_pend;
    logic [RB_INDEX-1:0]          issue_qj;
    logic [WORD_SIZE-1:0]         issue_vk;
    logic                         issue_qk_pend;
    logic [RB_INDEX-1:0]          issue_qk;
    logic [WORD_SIZE*RB_SIZE-1:0] cdb_data;
    logic [RB_SIZE-1:0]           cdb_valid;
    logic                         full;
    logic                         result_valid;
    logic                         result_taken;
    logic [RB_INDEX-1:0]          result_dest;

    modport master (
        output flush, issue_valid, issue_op, issue_dest,
               issue_vj, issue_qj_pend, issue_qj,
               issue_vk, issue_qk_pend, issue_qk,
               cdb_data, cdb_valid,
        input  full, result_valid, result_taken, result_dest
    );

    modport slave (
        input  flush, issue_valid, issue_op, issue_dest,
               issue_vj, issue_qj_pend, issue_qj,
               issue_vk, issue_qk_pend, issue_qk,
               cdb_data, cdb_valid,
        output full, result_valid, result_taken, result_dest
    );

endinterface

// File: rtl/branch_cmp.sv
// ---------------------------------------------------------------------------
// branch_cmp
// Purely combinational branch condition evaluator.
//   op_i    : compare mode (op_e)
//   a_i     : operand j (full WORD_SIZE, no extension/truncation)
//   b_i     : operand k
//   taken_o : 1 when the branch condition holds
// ---------------------------------------------------------------------------
module branch_cmp
    import branch_rs_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEF
) (
    input  op_e                  op_i,
    input  logic [WORD_SIZE-1:0] a_i,
    input  logic [WORD_SIZE-1:0] b_i,
    output logic                 taken_o
);

    // NOTE: every output of a combinational block gets a default before the
    // case, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        taken_o = 1'b0;
        case (op_i)
            OP_BGE:  taken_o = ($signed(a_i) >= $signed(b_i));
            OP_BLT:  taken_o = ($signed(a_i) <  $signed(b_i));
            OP_BEQ:  taken_o = (a_i == b_i);
            OP_BNE:  taken_o = (a_i != b_i);
            OP_BGEU: taken_o = (a_i >= b_i);
            OP_BLTU: taken_o = (a_i <  b_i);
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_rs_queue.sv
// ---------------------------------------------------------------------------
// branch_rs_queue
// Reservation station for branch instructions. Holds DEPTH entries, snoops
// the per-tag CDB for pending operands, and each cycle resolves the oldest
// ready entry, presenting a one-cycle registered result.
//
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   flush             : drop every entry and any result selected this cycle
//   issue_*           : new branch (op, RB dest tag, Vj/Qj, Vk/Qk)
//   cdb_data/cdb_valid: CDB broadcast, slot t carries the value of RB tag t
//   full              : all entries busy (registered state only)
//   result_*          : registered branch outcome, valid for one cycle
// ---------------------------------------------------------------------------
module branch_rs_queue
    import branch_rs_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int RB_INDEX  = RB_INDEX_DEF,
    parameter int RB_SIZE   = RB_SIZE_DEF,
    parameter int DEPTH     = DEPTH_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         issue_valid,
    input  logic [2:0]                   issue_op,
    input  logic [RB_INDEX-1:0]          issue_dest,
    input  logic [WORD_SIZE-1:0]         issue_vj,
    input  logic                         issue_qj_pend,
    input  logic [RB_INDEX-1:0]          issue_qj,
    input  logic [WORD_SIZE-1:0]         issue_vk,
    input  logic                         issue_qk_pend,
    input  logic [RB_INDEX-1:0]          issue_qk,
    input  logic [WORD_SIZE*RB_SIZE-1:0] cdb_data,
    input  logic [RB_SIZE-1:0]           cdb_valid,
    output logic                         full,
    output logic                         result_valid,
    output logic                         result_taken,
    output logic [RB_INDEX-1:0]          result_dest
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [WORD_SIZE-1:0] word_t;
    typedef logic [RB_INDEX-1:0]  tag_t;
    typedef logic [IDX_W-1:0]     idx_t;

    // ---------------- entry state ----------------
    logic [DEPTH-1:0] busy_q, busy_d;
    logic [DEPTH-1:0] pend_j_q, pend_j_d;
    logic [DEPTH-1:0] pend_k_q, pend_k_d;
    op_e              op_q   [DEPTH];
    op_e              op_d   [DEPTH];
    tag_t             dest_q [DEPTH];
    tag_t             dest_d [DEPTH];
    tag_t             qj_q   [DEPTH];
    tag_t             qj_d   [DEPTH];
    tag_t             qk_q   [DEPTH];
    tag_t             qk_d   [DEPTH];
    word_t            vj_q   [DEPTH];
    word_t            vj_d   [DEPTH];
    word_t            vk_q   [DEPTH];
    word_t            vk_d   [DEPTH];

    // age_q[i][j] == 1 : entry i was issued before entry j (both busy).
    logic [DEPTH-1:0] age_q [DEPTH];
    logic [DEPTH-1:0] age_d [DEPTH];

    // ---------------- result register ----------------
    logic res_valid_q, res_valid_d;
    logic res_taken_q, res_taken_d;
    tag_t res_dest_q,  res_dest_d;

    // ---------------- combinational helpers ----------------
    word_t            cdb_word [RB_SIZE];
    logic [DEPTH-1:0] ready;
    logic [DEPTH-1:0] sel_oh;
    logic             sel_any;
    idx_t             sel_idx;
    logic             sel_taken;
    idx_t             alloc_idx;
    logic             issue_ok;

    always_comb begin
        for (int t = 0; t < RB_SIZE; t++) begin
            cdb_word[t] = cdb_data[t*WORD_SIZE +: WORD_SIZE];
        end
    end

    assign full     = &busy_q;
    assign issue_ok = issue_valid && !full && !flush;

    // Oldest-ready select: an entry wins if no other ready entry is older.
    always_comb begin
        ready   = busy_q & ~pend_j_q & ~pend_k_q;
        sel_oh  = '0;
        sel_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            sel_oh[i] = ready[i];
            for (int j = 0; j < DEPTH; j++) begin
                if (j != i && ready[j] && age_q[j][i]) begin
                    sel_oh[i] = 1'b0;
                end
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (sel_oh[i]) begin
                sel_idx = idx_t'(i);
            end
        end
        sel_any = |sel_oh;
    end

    // Lowest-index free entry, looked up in registered busy only, so a slot
    // released on this edge is not reused until the next one.
    always_comb begin
        alloc_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                alloc_idx = idx_t'(i);
            end
        end
    end

    branch_cmp #(
        .WORD_SIZE (WORD_SIZE)
    ) u_cmp (
        .op_i    (op_q[sel_idx]),
        .a_i     (vj_q[sel_idx]),
        .b_i     (vk_q[sel_idx]),
        .taken_o (sel_taken)
    );

    // ---------------- next state ----------------
    always_comb begin
        busy_d   = busy_q;
        pend_j_d = pend_j_q;
        pend_k_d = pend_k_q;
        op_d     = op_q;
        dest_d   = dest_q;
        qj_d     = qj_q;
        qk_d     = qk_q;
        vj_d     = vj_q;
        vk_d     = vk_q;
        age_d    = age_q;

        // CDB wakeup of entries already waiting.
        for (int i = 0; i < DEPTH; i++) begin
            if (busy_q[i] && pend_j_q[i] && cdb_valid[qj_q[i]]) begin
                vj_d[i]     = cdb_word[qj_q[i]];
                pend_j_d[i] = 1'b0;
            end
            if (busy_q[i] && pend_k_q[i] && cdb_valid[qk_q[i]]) begin
                vk_d[i]     = cdb_word[qk_q[i]];
                pend_k_d[i] = 1'b0;
            end
        end

        if (sel_any) begin
            busy_d[sel_idx] = 1'b0;
        end

        if (issue_ok) begin
            busy_d[alloc_idx]   = 1'b1;
            op_d[alloc_idx]     = op_e'(issue_op);
            dest_d[alloc_idx]   = issue_dest;
            qj_d[alloc_idx]     = issue_qj;
            qk_d[alloc_idx]     = issue_qk;
            // Same-cycle bypass: a tag broadcast while issuing is taken now.
            pend_j_d[alloc_idx] = issue_qj_pend && !cdb_valid[issue_qj];
            pend_k_d[alloc_idx] = issue_qk_pend && !cdb_valid[issue_qk];
            vj_d[alloc_idx]     = (issue_qj_pend && cdb_valid[issue_qj]) ?
                                  cdb_word[issue_qj] : issue_vj;
            vk_d[alloc_idx]     = (issue_qk_pend && cdb_valid[issue_qk]) ?
                                  cdb_word[issue_qk] : issue_vk;
            // Newcomer is younger than every entry currently busy.
            for (int j = 0; j < DEPTH; j++) begin
                age_d[alloc_idx][j] = 1'b0;
                age_d[j][alloc_idx] = busy_q[j];
            end
        end

        if (flush) begin
            busy_d   = '0;
            pend_j_d = '0;
            pend_k_d = '0;
            for (int i = 0; i < DEPTH; i++) begin
                age_d[i] = '0;
            end
        end

        res_valid_d = sel_any && !flush;
        res_taken_d = res_valid_d && sel_taken;
        res_dest_d  = res_valid_d ? dest_q[sel_idx] : DEST_RESET[RB_INDEX-1:0];
    end

    // ---------------- registers ----------------
    // NOTE: sequential state is updated only with non-blocking assignments so
    // every register samples the pre-edge value of its inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q      <= '0;
            pend_j_q    <= '0;
            pend_k_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                age_q[i] <= '0;
            end
            res_valid_q <= 1'b0;
            res_taken_q <= 1'b0;
            res_dest_q  <= DEST_RESET[RB_INDEX-1:0];
        end else begin
            busy_q      <= busy_d;
            pend_j_q    <= pend_j_d;
            pend_k_q    <= pend_k_d;
            age_q       <= age_d;
            res_valid_q <= res_valid_d;
            res_taken_q <= res_taken_d;
            res_dest_q  <= res_dest_d;
        end
    end

    // NOTE: entry payload is left unreset; it is only ever read while the
    // entry's busy bit is set, and busy is reset above.
    always_ff @(posedge clk) begin
        op_q   <= op_d;
        dest_q <= dest_d;
        qj_q   <= qj_d;
        qk_q   <= qk_d;
        vj_q   <= vj_d;
        vk_q   <= vk_d;
    end

    assign result_valid = res_valid_q;
    assign result_taken = res_taken_q;
    assign result_dest  = res_dest_q;

endmodule

// File: tb/tb_branch_rs_queue.sv
// ---------------------------------------------------------------------------
// tb_branch_rs_queue
// Directed bench for branch_rs_queue. Stimulus pushes the hand-computed
// result (taken, dest, cycle it must appear in) into a scoreboard; a monitor
// on the falling edge pops and compares whenever result_valid is high.
// ---------------------------------------------------------------------------
module tb_branch_rs_queue;
    import branch_rs_pkg::*;

    localparam int WS = 32;
    localparam int RI = 4;
    localparam int RS = 16;
    localparam int DP = 4;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    branch_rs_queue_if #(.WORD_SIZE(WS), .RB_INDEX(RI), .RB_SIZE(RS)) bus ();

    branch_rs_queue #(
        .WORD_SIZE (WS), .RB_INDEX (RI), .RB_SIZE (RS), .DEPTH (DP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (bus.flush),
        .issue_valid   (bus.issue_valid),
        .issue_op      (bus.issue_op),
        .issue_dest    (bus.issue_dest),
        .issue_vj      (bus.issue_vj),
        .issue_qj_pend (bus.issue_qj_pend),
        .issue_qj      (bus.issue_qj),
        .issue_vk      (bus.issue_vk),
        .issue_qk_pend (bus.issue_qk_pend),
        .issue_qk      (bus.issue_qk),
        .cdb_data      (bus.cdb_data),
        .cdb_valid     (bus.cdb_valid),
        .full          (bus.full),
        .result_valid  (bus.result_valid),
        .result_taken  (bus.result_taken),
        .result_dest   (bus.result_dest)
    );

    typedef struct {
        logic       taken;
        logic [3:0] dest;
        int         at;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        t;
        logic [3:0]  d;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.flush         = 1'b0;
        bus.issue_valid   = 1'b0;
        bus.issue_op      = '0;
        bus.issue_dest    = '0;
        bus.issue_vj      = '0;
        bus.issue_qj_pend = 1'b0;
        bus.issue_qj      = '0;
        bus.issue_vk      = '0;
        bus.issue_qk_pend = 1'b0;
        bus.issue_qk      = '0;
        bus.cdb_valid     = '0;
        bus.cdb_data      = '0;
    endtask

    task automatic set_issue(input logic [2:0] op, input logic [3:0] dest,
                             input logic [31:0] vj, input logic pj, input logic [3:0] qj,
                             input logic [31:0] vk, input logic pk, input logic [3:0] qk);
        bus.issue_valid   = 1'b1;
        bus.issue_op      = op;
        bus.issue_dest    = dest;
        bus.issue_vj      = vj;
        bus.issue_qj_pend = pj;
        bus.issue_qj      = qj;
        bus.issue_vk      = vk;
        bus.issue_qk_pend = pk;
        bus.issue_qk      = qk;
    endtask

    task automatic set_cdb(input logic [3:0] tag, input logic [31:0] data);
        bus.cdb_valid[tag]          = 1'b1;
        bus.cdb_data[tag*WS +: WS]  = data;
    endtask

    task automatic expect_res(input logic taken, input logic [3:0] dest, input int at);
        exp_t e;
        e.taken = taken;
        e.dest  = dest;
        e.at    = at;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Monitor: every falling edge, compare a presented result against the
    // scoreboard head, or confirm the idle outputs are zero.
    always @(negedge clk) begin
        if (bus.result_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got dest %0d taken %0d expected none (cycle %0d)",
                         bus.result_dest, bus.result_taken, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result_taken", 64'(bus.result_taken), 64'(e.taken));
                check("result_dest",  64'(bus.result_dest),  64'(e.dest));
                check("result_cycle", 64'(cyc),              64'(e.at));
            end
        end else begin
            check("idle_taken", 64'(bus.result_taken), 64'd0);
            check("idle_dest",  64'(bus.result_dest),  64'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs [10];
        int   e0;

        vecs[0] = '{3'd0, 32'hFFFF_FFFE, 32'd1,        1'b0, 4'd3};
        vecs[1] = '{3'd0, 32'd3,         32'd3,        1'b1, 4'd4};
        vecs[2] = '{3'd2, 32'h8000_0000, 32'd0,        1'b0, 4'd5};
        vecs[3] = '{3'd3, 32'd4,         32'd4,        1'b0, 4'd6};
        vecs[4] = '{3'd3, 32'h8000_0000, 32'd0,        1'b1, 4'd8};
        vecs[5] = '{3'd4, 32'hFFFF_FFFF, 32'd1,        1'b1, 4'd9};
        vecs[6] = '{3'd5, 32'd1,         32'hFFFF_FFFF, 1'b1, 4'd10};
        vecs[7] = '{3'd1, 32'd7,         32'd7,        1'b0, 4'd11};
        vecs[8] = '{3'd6, 32'd5,         32'd3,        1'b0, 4'd12};
        vecs[9] = '{3'd7, 32'd0,         32'd0,        1'b0, 4'd13};

        clear_inputs();
        reset = 1'b1;
        idle(2);
        check("reset_full",         64'(bus.full),         64'd0);
        check("reset_result_valid", 64'(bus.result_valid), 64'd0);
        check("reset_result_taken", 64'(bus.result_taken), 64'd0);
        check("reset_result_dest",  64'(bus.result_dest),  64'd0);
        reset = 1'b0;
        idle(1);

        // BGE 5 >= 3, two-cycle latency, one cycle wide.
        set_issue(3'd0, 4'd7, 32'd5, 1'b0, 4'd0, 32'd3, 1'b0, 4'd0);
        tick();
        expect_res(1'b1, 4'd7, cyc + 1);
        clear_inputs();
        idle(3);

        // BLT -1 < 1 signed, then BLTU 0xFFFFFFFF < 1 unsigned.
        set_issue(3'd1, 4'd1, 32'hFFFF_FFFF, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0);
        tick();
        expect_res(1'b1, 4'd1, cyc + 1);
        set_issue(3'd5, 4'd2, 32'hFFFF_FFFF, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0);
        tick();
        expect_res(1'b0, 4'd2, cyc + 1);
        clear_inputs();
        idle(3);

        // Compare-mode table, one issue per cycle.
        for (int i = 0; i < 10; i++) begin
            set_issue(vecs[i].op, vecs[i].d, vecs[i].a, 1'b0, 4'd0, vecs[i].b, 1'b0, 4'd0);
            tick();
            expect_res(vecs[i].t, vecs[i].d, cyc + 1);
        end
        clear_inputs();
        idle(3);

        // BEQ waiting on tag 3; a decoy on tag 2 must be ignored.
        set_issue(3'd2, 4'd4, 32'd0, 1'b1, 4'd3, 32'd9, 1'b0, 4'd0);
        tick();
        e0 = cyc;
        clear_inputs();
        set_cdb(4'd2, 32'd0);
        tick();
        clear_inputs();
        set_cdb(4'd3, 32'd9);
        tick();
        expect_res(1'b1, 4'd4, e0 + 3);
        clear_inputs();
        idle(3);

        // Same-cycle bypass on tag 3.
        set_issue(3'd2, 4'd5, 32'd0, 1'b1, 4'd3, 32'd9, 1'b0, 4'd0);
        set_cdb(4'd3, 32'd9);
        tick();
        expect_res(1'b1, 4'd5, cyc + 1);
        clear_inputs();
        idle(3);

        // Both operands pending, both captured in one cycle: BLTU 2 < 100.
        set_issue(3'd5, 4'd6, 32'hFFFF_FFFF, 1'b1, 4'd1, 32'd0, 1'b1, 4'd12);
        tick();
        clear_inputs();
        set_cdb(4'd1, 32'd2);
        set_cdb(4'd12, 32'd100);
        tick();
        expect_res(1'b1, 4'd6, cyc + 1);
        clear_inputs();
        idle(3);

        // Fill all four entries, drop issues while full, drain in issue order.
        set_issue(3'd3, 4'd1, 32'd0, 1'b1, 4'd2, 32'd5, 1'b0, 4'd0);  tick();
        set_issue(3'd2, 4'd2, 32'd0, 1'b1, 4'd6, 32'd8, 1'b0, 4'd0);  tick();
        set_issue(3'd1, 4'd3, 32'd0, 1'b1, 4'd6, 32'd8, 1'b0, 4'd0);  tick();
        set_issue(3'd0, 4'd4, 32'd0, 1'b1, 4'd6, 32'd8, 1'b0, 4'd0);  tick();
        check("full_after_fill", 64'(bus.full), 64'd1);
        set_issue(3'd2, 4'd15, 32'd1, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0); tick();
        check("full_after_drop", 64'(bus.full), 64'd1);
        clear_inputs();
        set_cdb(4'd6, 32'd8);
        set_cdb(4'd2, 32'd7);
        tick();
        e0 = cyc;
        clear_inputs();
        // Entry 0 completes on this edge, but the issue sees full and drops.
        set_issue(3'd2, 4'd14, 32'd1, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0);
        tick();
        expect_res(1'b1, 4'd1, e0 + 1);
        expect_res(1'b1, 4'd2, e0 + 2);
        expect_res(1'b0, 4'd3, e0 + 3);
        expect_res(1'b1, 4'd4, e0 + 4);
        check("full_after_free", 64'(bus.full), 64'd0);
        clear_inputs();
        idle(6);

        // Age beats index: W reuses entry 0 after Y took entry 1.
        set_issue(3'd2, 4'd1, 32'd1, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0);
        tick();
        e0 = cyc;
        expect_res(1'b1, 4'd1, e0 + 1);
        set_issue(3'd3, 4'd2, 32'd0, 1'b1, 4'd9, 32'd0, 1'b0, 4'd0);
        tick();
        set_issue(3'd1, 4'd3, 32'd0, 1'b1, 4'd9, 32'd0, 1'b0, 4'd0);
        tick();
        clear_inputs();
        set_cdb(4'd9, 32'hFFFF_FFFF);
        tick();
        expect_res(1'b1, 4'd2, e0 + 4);
        expect_res(1'b1, 4'd3, e0 + 5);
        clear_inputs();
        idle(4);

        // Flush in the cycle the oldest entry is selected.
        set_issue(3'd2, 4'd5, 32'd0, 1'b1, 4'd10, 32'd3, 1'b0, 4'd0); tick();
        set_issue(3'd2, 4'd6, 32'd0, 1'b1, 4'd10, 32'd3, 1'b0, 4'd0); tick();
        clear_inputs();
        set_cdb(4'd10, 32'd3);
        tick();
        clear_inputs();
        bus.flush = 1'b1;
        set_issue(3'd2, 4'd15, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
        tick();
        clear_inputs();
        check("flush_full", 64'(bus.full), 64'd0);
        set_issue(3'd3, 4'd7, 32'd1, 1'b0, 4'd0, 32'd2, 1'b0, 4'd0);
        tick();
        expect_res(1'b1, 4'd7, cyc + 1);
        clear_inputs();
        idle(4);

        // Same scenario with reset in place of flush.
        set_issue(3'd2, 4'd5, 32'd0, 1'b1, 4'd10, 32'd3, 1'b0, 4'd0); tick();
        set_issue(3'd2, 4'd6, 32'd0, 1'b1, 4'd10, 32'd3, 1'b0, 4'd0); tick();
        clear_inputs();
        set_cdb(4'd10, 32'd3);
        tick();
        clear_inputs();
        reset = 1'b1;
        bus.flush = 1'b1;
        set_issue(3'd2, 4'd15, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
        tick();
        reset = 1'b0;
        clear_inputs();
        check("rst_full",         64'(bus.full),         64'd0);
        check("rst_result_valid", 64'(bus.result_valid), 64'd0);
        check("rst_result_taken", 64'(bus.result_taken), 64'd0);
        check("rst_result_dest",  64'(bus.result_dest),  64'd0);
        set_issue(3'd4, 4'd8, 32'd9, 1'b0, 4'd0, 32'd9, 1'b0, 4'd0);
        tick();
        expect_res(1'b1, 4'd8, cyc + 1);
        clear_inputs();
        idle(5);

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
